// File: rtl/alu2.sv
// Single-cycle registered ALU: add/sub/logic/shift with carry, zero, negative
// and signed-overflow flags, all updated together one clock after sampling.
module alu2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Result,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [SW-1:0]    w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl_ext;
    logic [WIDTH:0]   w_shr_ext;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;

    assign w_shamt = B[SW-1:0];
    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_diff  = {1'b0, A} - {1'b0, B};

    // One guard bit beyond each end captures the last bit shifted out; it
    // stays 0 for a zero shift amount.
    assign w_shl_ext = {1'b0, A} << w_shamt;
    assign w_shr_ext = {A, 1'b0} >> w_shamt;

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                w_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: w_result = A & B;
            OP_OR:  w_result = A | B;
            OP_XOR: w_result = A ^ B;
            OP_NOT: w_result = ~A;
            OP_SHL: begin
                w_result = w_shl_ext[WIDTH-1:0];
                w_carry  = w_shl_ext[WIDTH];
            end
            OP_SHR: begin
                w_result = w_shr_ext[WIDTH:1];
                w_carry  = w_shr_ext[0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            Result <= w_result;
            carry  <= w_carry;
            zero   <= (w_result == '0);
            neg    <= w_result[WIDTH-1];
            ovf    <= w_ovf;
        end
    end

endmodule

// File: tb/tb_alu2.sv
// Directed self-checking bench for alu2 (WIDTH=16); expected values hand-computed.
module tb_alu2;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] Result;
    logic [2:0]   opcode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    alu2 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .Result (Result),
        .opcode (opcode),
        .A      (A),
        .B      (B),
        .carry  (carry),
        .zero   (zero),
        .neg    (neg),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation on the falling edge, then settle just after the next rising edge.
    task automatic drive(input logic r, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        rst    = r;
        opcode = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 3'b000, 16'h1234, 16'h4321);
        checks++;
        if (Result !== 16'h0000 || {carry, zero, neg, ovf} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_state got R=%h czno=%b exp R=0000 czno=0100", Result, {carry, zero, neg, ovf});
        end
    endtask

    // Table-driven vectors: opcode, A, B, expected Result, expected {carry,zero,neg,ovf}.
    task automatic test_arith();
        logic [2:0]   op [8];
        logic [W-1:0] a  [8];
        logic [W-1:0] b  [8];
        logic [W-1:0] er [8];
        logic [3:0]   ef [8];
        op[0]=3'b000; a[0]=16'd200;   b[0]=16'd61; er[0]=16'd261;   ef[0]=4'b0000;
        op[1]=3'b000; a[1]=16'd0;     b[1]=16'd0;  er[1]=16'd0;     ef[1]=4'b0100;
        op[2]=3'b001; a[2]=16'd1;     b[2]=16'd3;  er[2]=16'hFFFE;  ef[2]=4'b1010;
        op[3]=3'b001; a[3]=16'h8000;  b[3]=16'd1;  er[3]=16'h7FFF;  ef[3]=4'b0001;
        op[4]=3'b000; a[4]=16'hFFFF;  b[4]=16'd1;  er[4]=16'h0000;  ef[4]=4'b1100;
        op[5]=3'b000; a[5]=16'h7FFF;  b[5]=16'd1;  er[5]=16'h8000;  ef[5]=4'b0011;
        op[6]=3'b001; a[6]=16'd7;     b[6]=16'd7;  er[6]=16'h0000;  ef[6]=4'b0100;
        op[7]=3'b001; a[7]=16'h7FFF;  b[7]=16'hFFFF; er[7]=16'h8000; ef[7]=4'b1011;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, op[i], a[i], b[i]);
            checks++;
            if (Result !== er[i] || {carry, zero, neg, ovf} !== ef[i]) begin
                failures++;
                $display("FAIL arith[%0d] got R=%h czno=%b exp R=%h czno=%b", i, Result, {carry, zero, neg, ovf}, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [2:0]   op [5];
        logic [W-1:0] a  [5];
        logic [W-1:0] b  [5];
        logic [W-1:0] er [5];
        logic [3:0]   ef [5];
        op[0]=3'b010; a[0]=16'd3;    b[0]=16'd4;    er[0]=16'd0;    ef[0]=4'b0100;
        op[1]=3'b011; a[1]=16'd10;   b[1]=16'd10;   er[1]=16'd10;   ef[1]=4'b0000;
        op[2]=3'b100; a[2]=16'd15;   b[2]=16'd1;    er[2]=16'd14;   ef[2]=4'b0000;
        op[3]=3'b101; a[3]=16'd20;   b[3]=16'hFFFF; er[3]=16'hFFEB; ef[3]=4'b0010;
        op[4]=3'b010; a[4]=16'hF0F0; b[4]=16'hFF00; er[4]=16'hF000; ef[4]=4'b0010;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, op[i], a[i], b[i]);
            checks++;
            if (Result !== er[i] || {carry, zero, neg, ovf} !== ef[i]) begin
                failures++;
                $display("FAIL logic[%0d] got R=%h czno=%b exp R=%h czno=%b", i, Result, {carry, zero, neg, ovf}, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [2:0]   op [7];
        logic [W-1:0] a  [7];
        logic [W-1:0] b  [7];
        logic [W-1:0] er [7];
        logic [3:0]   ef [7];
        op[0]=3'b110; a[0]=16'd34;   b[0]=16'd5;    er[0]=16'd1088;  ef[0]=4'b0000;
        op[1]=3'b111; a[1]=16'd255;  b[1]=16'd0;    er[1]=16'd255;   ef[1]=4'b0000;
        op[2]=3'b110; a[2]=16'h8001; b[2]=16'h0011; er[2]=16'h0002;  ef[2]=4'b1000;
        op[3]=3'b111; a[3]=16'h0003; b[3]=16'd1;    er[3]=16'h0001;  ef[3]=4'b1000;
        op[4]=3'b110; a[4]=16'h0002; b[4]=16'd15;   er[4]=16'h0000;  ef[4]=4'b1100;
        op[5]=3'b111; a[5]=16'h8000; b[5]=16'h00F4; er[5]=16'h0800;  ef[5]=4'b0000;
        op[6]=3'b110; a[6]=16'h8000; b[6]=16'h0010; er[6]=16'h8000;  ef[6]=4'b0010;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, op[i], a[i], b[i]);
            checks++;
            if (Result !== er[i] || {carry, zero, neg, ovf} !== ef[i]) begin
                failures++;
                $display("FAIL shift[%0d] got R=%h czno=%b exp R=%h czno=%b", i, Result, {carry, zero, neg, ovf}, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b0, 3'b101, 16'h0000, 16'h0000);
        drive(1'b1, 3'b000, 16'd5, 16'd5);
        checks++;
        if (Result !== 16'h0000 || {carry, zero, neg, ovf} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_priority got R=%h czno=%b exp R=0000 czno=0100", Result, {carry, zero, neg, ovf});
        end
        drive(1'b0, 3'b000, 16'd5, 16'd5);
        checks++;
        if (Result !== 16'd10 || {carry, zero, neg, ovf} !== 4'b0000) begin
            failures++;
            $display("FAIL first_after_reset got R=%h czno=%b exp R=000a czno=0000", Result, {carry, zero, neg, ovf});
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 3'b001, 16'd1, 16'd3);
        opcode = 3'b000;
        A      = 16'h0000;
        B      = 16'h0000;
        #3;
        checks++;
        if (Result !== 16'hFFFE || {carry, zero, neg, ovf} !== 4'b1010) begin
            failures++;
            $display("FAIL hold got R=%h czno=%b exp R=fffe czno=1010", Result, {carry, zero, neg, ovf});
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 3'b000, 16'd100, 16'd23);
        checks++;
        if (Result !== 16'd123) begin
            failures++;
            $display("FAIL b2b_0 got R=%h exp R=007b", Result);
        end
        drive(1'b0, 3'b100, 16'hAAAA, 16'h5555);
        checks++;
        if (Result !== 16'hFFFF || {carry, zero, neg, ovf} !== 4'b0010) begin
            failures++;
            $display("FAIL b2b_1 got R=%h czno=%b exp R=ffff czno=0010", Result, {carry, zero, neg, ovf});
        end
        drive(1'b0, 3'b011, 16'h0000, 16'h0000);
        checks++;
        if (Result !== 16'h0000 || {carry, zero, neg, ovf} !== 4'b0100) begin
            failures++;
            $display("FAIL b2b_2 got R=%h czno=%b exp R=0000 czno=0100", Result, {carry, zero, neg, ovf});
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 3'b000;
        A      = '0;
        B      = '0;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_reset_priority();
        test_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu2.md
ALU2 -- requirements
Module: alu2

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; a power of two, at least 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high, sampled on rising clk.
REQ-004 Result  output  WIDTH  registered operation result.
REQ-005 opcode  input  3  operation select.
REQ-006 A  input  WIDTH  first operand, unsigned or two's complement per operation.
REQ-007 B  input  WIDTH  second operand, or shift amount.
REQ-008 carry  output  1  registered carry-out or borrow flag.
REQ-009 zero  output  1  registered flag, set when the next Result is all zeros.
REQ-010 neg  output  1  registered flag equal to the MSB of the next Result.
REQ-011 ovf  output  1  registered signed-overflow flag.
REQ-012 Port declaration order SHALL be clk, rst, Result, opcode, A, B, carry, zero, neg, ovf.

Function
REQ-013 Opcode map: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 NOT A; 110 SHL A by B[log2(WIDTH)-1:0]; 111 SHR logical A by B[log2(WIDTH)-1:0].
REQ-014 Result, carry, zero, neg and ovf SHALL update together on each rising clk edge from the opcode, A and B sampled at that edge. Latency is exactly 1 cycle.
REQ-015 There is no handshake and no enable. A new operation is accepted every cycle.
REQ-016 All arithmetic is modulo 2^WIDTH. Result holds the low WIDTH bits.
REQ-017 ADD:
- carry = bit WIDTH of the unsigned sum.
- ovf = 1 when A and B have the same sign and the result sign differs.
REQ-018 SUB:
- carry = borrow, 1 if A < B unsigned.
- ovf = 1 when A and B have different signs and the result sign differs from A.
REQ-019 Logic ops and NOT: carry = 0, ovf = 0.
REQ-020 SHL: carry = last bit shifted out of the MSB; carry = 0 for a shift of 0; ovf = 0.
REQ-021 SHR: carry = last bit shifted out of the LSB; carry = 0 for a shift of 0; ovf = 0; vacated bits filled with 0.
REQ-022 Shift bits of B above the low log2(WIDTH) bits SHALL be ignored.
REQ-023 zero and neg SHALL be derived from the new Result for every opcode.
REQ-024 Outputs SHALL hold their value between clock edges regardless of input changes.
REQ-025 X/undefined opcode values do not occur. All 8 encodings are defined, so there is no default or illegal case.

Reset
REQ-026 While rst = 1 at a rising clk edge, Result = 0, carry = 0, zero = 1, neg = 0 and ovf = 0, overriding any operation.
REQ-027 rst has priority over a simultaneous operation. The first operation after reset SHALL be the one sampled on the first edge with rst = 0.
REQ-028 Asserting rst between operations discards the in-flight result. No partial state survives.

Verification
REQ-029 ADD: A=200, B=61, op=000 -> next edge Result=261, carry=0, zero=0. A=0, B=0, op=000 -> Result=0, zero=1.
REQ-030 SUB: A=1, B=3, op=001 -> Result=0xFFFE, carry=1, neg=1, ovf=0. A=0x8000, B=1 -> Result=0x7FFF, ovf=1.
REQ-031 Logic: A=3, B=4, op=010 -> Result=0, zero=1. A=10, B=10, op=011 -> 10. A=15, B=1, op=100 -> 14. A=20, op=101 -> 0xFFEB, neg=1.
REQ-032 Shifts:
- A=34, B=5, op=110 -> Result=1088, carry=0.
- A=255, B=0, op=111 -> Result=255, carry=0.
- A=0x8001, B=0x0011, op=110 -> shift 1 -> Result=0x0002, carry=1.
REQ-033 ADD overflow: A=0xFFFF, B=1, op=000 -> Result=0, carry=1, zero=1, ovf=0. A=0x7FFF, B=1 -> Result=0x8000, ovf=1, neg=1.
REQ-034 Reset: drive op=000, A=5, B=5 with rst=1 for one edge -> Result=0, zero=1. Deassert rst -> Result=10 on the following edge.
